// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sequencer/coefficient controller.
//   N           filter tap count
//   DATA_WIDTH  sample width
//   COEFF_WIDTH coefficient width (Q16.14)
//   LATENCY     fir_ce pulses from a sample entering the filter to its result
//   ADDR_WIDTH  coefficient address width
package fir_pkg;

  localparam int unsigned N           = 37;
  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned COEFF_WIDTH = 16;
  localparam int unsigned LATENCY     = 9;
  localparam int unsigned ADDR_WIDTH  = 6;
  localparam int unsigned WARM_WIDTH  = $clog2(N);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_t;

  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

  // Writes beyond the last tap are dropped.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return addr < ADDR_WIDTH'(N);
  endfunction

endpackage

// File: rtl/fir_tag_tracker.sv
// Tags every fir_ce pulse as real (1) or flush (0) and follows it through the
// filter pipeline, producing out_valid/out_warm when a real result appears.
// tags[0] is the tag of the sample currently on fir_x; tags[LATENCY-1] is the
// stage whose result reaches the filter output on the next fir_ce pulse.
// Macro FIR_WARMUP_MASK_EN: warm-up results are suppressed instead of flagged.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         clears tags and restarts the warm-up count
//   ce          registered filter clock-enable (current cycle)
//   load        fir_ce for the next cycle
//   load_tag    tag for the sample loaded with load
//   pend_c      some real sample remains in flight after this edge (no new load)
//   out_valid   registered: filter output holds a real result
//   out_warm    registered: that result was produced with incomplete history
module fir_tag_tracker
  import fir_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ce,
  input  logic load,
  input  logic load_tag,
  output logic pend_c,
  output logic out_valid,
  output logic out_warm
);

  logic [LATENCY-1:0]    tags;
  logic [WARM_WIDTH-1:0] warm_cnt;
  logic                  result_c;
  logic                  warm_c;

  assign result_c = ce & tags[LATENCY-1];
  assign warm_c   = (warm_cnt != '0);

  // The last stage leaves on a ce pulse; otherwise nothing moves.
  assign pend_c = ce ? (|tags[LATENCY-2:0]) : (|tags);

  // Tag shift register, warm-up counter and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags      <= '0;
      warm_cnt  <= WARM_WIDTH'(N - 1);
      out_valid <= 1'b0;
      out_warm  <= 1'b0;
    end else if (clr) begin
      tags      <= '0;
      warm_cnt  <= WARM_WIDTH'(N - 1);
      out_valid <= 1'b0;
      out_warm  <= 1'b0;
    end else begin
      tags[0] <= load & load_tag;
      if (ce) begin
        tags[LATENCY-1:1] <= tags[LATENCY-2:0];
      end
      if (result_c && warm_c) begin
        warm_cnt <= warm_cnt - WARM_WIDTH'(1);
      end
`ifdef FIR_WARMUP_MASK_EN
      out_valid <= result_c & ~warm_c;
      out_warm  <= 1'b0;
`else
      out_valid <= result_c;
      out_warm  <= result_c & warm_c;
`endif
    end
  end

endmodule

// File: rtl/fir_coeff_seq_ctrl.sv
// Sequencer and double-buffered coefficient controller for the ECG FIR.
// Accepts samples over valid/ready, drives the filter clock-enable and input,
// and swaps the shadow coefficient bank into the active bank only after the
// pipeline has been drained of real samples.
// Macro FIR_WARMUP_MASK_EN (in fir_tag_tracker): mask warm-up results.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   upstream sample handshake
//   fir_ce, fir_x, fir_clr   filter clock-enable, input sample, clear pulse
//   coeff_flat               active bank, tap i at [i*COEFF_WIDTH +: COEFF_WIDTH]
//   out_valid, out_warm      result qualifiers aligned to the filter output
//   cfg_wr_en/addr/data      shadow bank write port
//   cfg_commit, cfg_busy     swap request and pending/in-progress flag
module fir_coeff_seq_ctrl
  import fir_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         fir_ce,
  output logic [DATA_WIDTH-1:0]        fir_x,
  output logic                         fir_clr,
  output logic [N*COEFF_WIDTH-1:0]     coeff_flat,
  output logic                         out_valid,
  output logic                         out_warm,
  input  logic                         cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]        cfg_addr,
  input  logic [COEFF_WIDTH-1:0]       cfg_data,
  input  logic                         cfg_commit,
  output logic                         cfg_busy
);

  state_t                state_q;
  state_t                state_d;
  logic                  ce_d;
  logic                  tag_d;
  logic [DATA_WIDTH-1:0] x_d;
  logic                  pend_c;

  coeff_t shadow [N];
  coeff_t active [N];

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    tag_d   = 1'b0;
    x_d     = '0;
    case (state_q)
      RUN: begin
        if (s_valid && s_ready) begin
          ce_d  = 1'b1;
          tag_d = 1'b1;
          x_d   = s_data;
        end
        if (cfg_commit) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Flush with zeros until the last real sample has left the filter.
        if (pend_c) begin
          ce_d = 1'b1;
        end else begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and handshake/filter control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      s_ready  <= 1'b1;
      fir_ce   <= 1'b0;
      fir_x    <= '0;
      fir_clr  <= 1'b0;
      cfg_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_ready  <= (state_d == RUN);
      fir_ce   <= ce_d;
      fir_x    <= x_d;
      fir_clr  <= (state_d == SWAP);
      cfg_busy <= (state_d != RUN);
    end
  end

  // Coefficient banks; a shadow write in the SWAP cycle lands after the copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cfg_wr_en && addr_in_range(cfg_addr)) begin
        shadow[cfg_addr] <= coeff_t'(cfg_data);
      end
      if (state_q == SWAP) begin
        for (int i = 0; i < N; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  // Flatten the active bank for the filter.
  always_comb begin
    coeff_flat = '0;
    for (int i = 0; i < N; i++) begin
      coeff_flat[i*COEFF_WIDTH +: COEFF_WIDTH] = active[i];
    end
  end

  fir_tag_tracker u_tags (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == SWAP),
    .ce        (fir_ce),
    .load      (ce_d),
    .load_tag  (tag_d),
    .pend_c    (pend_c),
    .out_valid (out_valid),
    .out_warm  (out_warm)
  );

endmodule

// File: tb/tb_fir_coeff_seq_ctrl.sv
// Scoreboard bench for fir_coeff_seq_ctrl: stimulus pushes the expected fir_x
// values and result flags; negedge monitors pop and compare them.
module tb_fir_coeff_seq_ctrl;
  import fir_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_WIDTH-1:0]    s_data;
  logic                     fir_ce;
  logic [DATA_WIDTH-1:0]    fir_x;
  logic                     fir_clr;
  logic [N*COEFF_WIDTH-1:0] coeff_flat;
  logic                     out_valid;
  logic                     out_warm;
  logic                     cfg_wr_en;
  logic [ADDR_WIDTH-1:0]    cfg_addr;
  logic [COEFF_WIDTH-1:0]   cfg_data;
  logic                     cfg_commit;
  logic                     cfg_busy;

  typedef struct {
    logic [DATA_WIDTH-1:0] x;
    logic                  flush;
  } fexp_t;

  fexp_t exp_x [$];
  logic  exp_w [$];
  int    errors = 0;
  int    checks = 0;
  int    clr_cnt = 0;
  int    clr_mark;
  logic [N*COEFF_WIDTH-1:0] exp_flat;

  always #5 clk = ~clk;

  fir_coeff_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .fir_ce     (fir_ce),
    .fir_x      (fir_x),
    .fir_clr    (fir_clr),
    .coeff_flat (coeff_flat),
    .out_valid  (out_valid),
    .out_warm   (out_warm),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_x(input int v, input logic flush);
    fexp_t e;
    e.x     = DATA_WIDTH'(v);
    e.flush = flush;
    exp_x.push_back(e);
  endtask

  task automatic push_flushes();
    for (int i = 0; i < LATENCY - 1; i++) push_x(0, 1'b1);
  endtask

  // Wait for a busy period to end, bounded.
  task automatic wait_idle(input int limit);
    bit seen = 0;
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (cfg_busy) seen = 1;
      else if (seen) done = 1;
    end
    chk("commit_completes", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"},   32'(s_ready),   32'd1);
    chk({tag, "_fir_ce"},    32'(fir_ce),    32'd0);
    chk({tag, "_fir_x"},     32'(fir_x),     32'd0);
    chk({tag, "_fir_clr"},   32'(fir_clr),   32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_warm"},  32'(out_warm),  32'd0);
    chk({tag, "_cfg_busy"},  32'(cfg_busy),  32'd0);
    chk({tag, "_coeff_zero"}, 32'(coeff_flat == '0), 32'd1);
  endtask

  // Filter-input monitor.
  always @(negedge clk) begin
    if (!rst && fir_ce) begin
      if (exp_x.size() == 0) begin
        chk("fir_ce_unexpected", 32'(fir_ce), 32'd0);
      end else begin
        fexp_t e;
        e = exp_x.pop_front();
        chk("fir_x", 32'(fir_x), 32'(e.x));
        if (e.flush) chk("s_ready_in_drain", 32'(s_ready), 32'd0);
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_w.size() == 0) begin
          chk("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          logic w;
          w = exp_w.pop_front();
          chk("out_warm", 32'(out_warm), 32'(w));
        end
      end else if (out_warm) begin
        chk("out_warm_without_valid", 32'(out_warm), 32'd0);
      end
      if (fir_clr) clr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    cfg_wr_en  = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_s_ready", 32'(s_ready), 32'd1);

    // Continuous stream 1..60, then drain via a commit.
    tick();
    for (int k = 1; k <= 60; k++) begin
      s_valid = 1'b1;
      s_data  = DATA_WIDTH'(k);
      push_x(k, 1'b0);
`ifdef FIR_WARMUP_MASK_EN
      if (k > 36) exp_w.push_back(1'b0);
`else
      exp_w.push_back(k <= 36);
`endif
      tick();
    end
    s_valid    = 1'b0;
    cfg_commit = 1'b1;
    push_flushes();
    clr_mark = clr_cnt;
    tick();
    cfg_commit = 1'b0;
    wait_idle(40);
    repeat (2) @(negedge clk);
    chk("stream_fir_q_empty", 32'(exp_x.size()), 32'd0);
    chk("stream_out_q_empty", 32'(exp_w.size()), 32'd0);
    chk("stream_clr_count", 32'(clr_cnt - clr_mark), 32'd1);

    // Commit with no traffic; a write in the SWAP cycle misses the copy.
    tick();
    cfg_wr_en = 1'b1;
    cfg_addr  = 6'd0;
    cfg_data  = 16'h4000;
    tick();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b1;
    @(negedge clk);
    chk("idle_busy_before", 32'(cfg_busy), 32'd0);
    tick();
    cfg_commit = 1'b0;
    @(negedge clk);
    chk("drain_busy", 32'(cfg_busy), 32'd1);
    chk("drain_s_ready", 32'(s_ready), 32'd0);
    chk("drain_clr", 32'(fir_clr), 32'd0);
    tick();
    cfg_wr_en = 1'b1;
    cfg_addr  = 6'd1;
    cfg_data  = 16'h1111;
    @(negedge clk);
    chk("swap_clr", 32'(fir_clr), 32'd1);
    chk("swap_busy", 32'(cfg_busy), 32'd1);
    chk("swap_tap0_old", 32'(coeff_flat[15:0]), 32'h0);
    tick();
    cfg_wr_en = 1'b0;
    @(negedge clk);
    chk("run_busy", 32'(cfg_busy), 32'd0);
    chk("run_clr", 32'(fir_clr), 32'd0);
    chk("run_s_ready", 32'(s_ready), 32'd1);
    chk("tap0_new", 32'(coeff_flat[15:0]), 32'h4000);
    chk("tap1_missed_copy", 32'(coeff_flat[31:16]), 32'h0);

    // One sample, then commit the next cycle: 8 flushes, one result.
    tick();
    s_valid = 1'b1;
    s_data  = 16'h1234;
    push_x(16'h1234, 1'b0);
`ifndef FIR_WARMUP_MASK_EN
    exp_w.push_back(1'b1);
`endif
    tick();
    s_valid    = 1'b0;
    cfg_commit = 1'b1;
    push_flushes();
    clr_mark = clr_cnt;
    tick();
    cfg_commit = 1'b0;
    wait_idle(40);
    chk("single_s_ready_after", 32'(s_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("single_fir_q_empty", 32'(exp_x.size()), 32'd0);
    chk("single_out_q_empty", 32'(exp_w.size()), 32'd0);
    chk("single_clr_count", 32'(clr_cnt - clr_mark), 32'd1);

    // Out-of-range write, then a second commit while draining.
    tick();
    cfg_wr_en = 1'b1;
    cfg_addr  = 6'd40;
    cfg_data  = 16'h7777;
    tick();
    cfg_wr_en = 1'b0;
    s_valid   = 1'b1;
    s_data    = 16'h0005;
    push_x(5, 1'b0);
`ifndef FIR_WARMUP_MASK_EN
    exp_w.push_back(1'b1);
`endif
    tick();
    s_valid    = 1'b0;
    cfg_commit = 1'b1;
    push_flushes();
    clr_mark = clr_cnt;
    tick();
    cfg_commit = 1'b0;
    tick();
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    wait_idle(40);
    repeat (15) @(negedge clk);
    chk("double_commit_clr_count", 32'(clr_cnt - clr_mark), 32'd1);
    chk("double_commit_busy_after", 32'(cfg_busy), 32'd0);
    chk("double_fir_q_empty", 32'(exp_x.size()), 32'd0);
    chk("double_out_q_empty", 32'(exp_w.size()), 32'd0);
    exp_flat = '0;
    exp_flat[15:0]  = 16'h4000;
    exp_flat[31:16] = 16'h1111;
    chk("coeff_bank_after_swap", 32'(coeff_flat == exp_flat), 32'd1);

    // Reset mid-stream.
    tick();
    for (int k = 1; k <= 3; k++) begin
      s_valid = 1'b1;
      s_data  = DATA_WIDTH'(100 + k);
      push_x(100 + k, 1'b0);
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_x.delete();
    exp_w.delete();
    chk_reset_outputs("midreset");
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_s_ready_after", 32'(s_ready), 32'd1);
    chk("midreset_busy_after", 32'(cfg_busy), 32'd0);

    // Shadow was cleared by reset: a commit keeps the bank at zero.
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    wait_idle(20);
    chk("shadow_cleared", 32'(coeff_flat == '0), 32'd1);
    chk("final_fir_q_empty", 32'(exp_x.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
